flb_code_stepper: RTL and testbench

//  Slew-limited sequencer for the FLB thermometer-coded tuning bank.
//  - Accepts a target 4-bit tuning code over a valid/ready handshake.
//  - Ramps the applied code toward the target one LSB at a time, waiting SETTLE_CYCLES after each step.
//  - Drives the bank through an internal binary-to-thermometer decoder.
//  - Sits between the DPLL loop logic and the fine-tuning DAC; stops large code jumps from glitching the oscillator.

---
 rtl/flb_pkg.sv | 9 +
 rtl/flb_code_stepper_b2t.sv | 17 +
 rtl/flb_code_stepper.sv | 89 ++++++++
 tb/tb_flb_code_stepper.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/flb_pkg.sv
// Shared types and widths for the FLB tuning-bank code stepper.
package flb_pkg;

  localparam int CODE_W_DEF = 4;
  localparam int THERMO_W   = 2**CODE_W_DEF;

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, DONE} flb_step_state_t;

endpackage

// File: rtl/flb_code_stepper_b2t.sv
// Binary-to-thermometer decoder: bit i is set when code > i.
module flb_code_stepper_b2t #(
  parameter int CODE_W = 4
) (
  input  logic [CODE_W-1:0]      code,
  output logic [2**CODE_W-1:0]   thermo
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**CODE_W; gi++) begin : g_bit
      localparam logic [CODE_W:0] IDX = (CODE_W+1)'(gi);
      assign thermo[gi] = ({1'b0, code} > IDX);
    end
  endgenerate

endmodule

// File: rtl/flb_code_stepper.sv
// Slew-limited sequencer: ramps the applied tuning code one LSB per step toward a target.
module flb_code_stepper
  import flb_pkg::*;
#(
  parameter int CODE_W        = CODE_W_DEF,
  parameter int SETTLE_CYCLES = 8,
  parameter int INIT_CODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_W-1:0]     tgt_code,
  input  logic                  tgt_valid,
  output logic                  tgt_ready,
  input  logic                  hold,
  output logic [CODE_W-1:0]     cur_code,
  output logic [2**CODE_W-1:0]  thermo,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CODE_W-1:0] INIT_C   = CODE_W'(INIT_CODE);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  flb_step_state_t   state_reg, state_next;
  logic [CODE_W-1:0] cur_reg, cur_next;
  logic [CODE_W-1:0] tgt_reg, tgt_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_reg   <= INIT_C;
      tgt_reg   <= INIT_C;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      tgt_reg   <= tgt_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (tgt_valid) begin
          tgt_next   = tgt_code;
          state_next = (tgt_code == cur_reg) ? DONE : STEP;
        end
      end
      STEP: begin
        // Direction is re-derived from the target every step, so the code can never wrap.
        if (!hold) begin
          cur_next   = (tgt_reg > cur_reg) ? cur_reg + CODE_W'(1) : cur_reg - CODE_W'(1);
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (!hold) begin
          if (cnt_reg != '0)
            cnt_next = cnt_reg - CNT_W'(1);
          else if (cur_reg == tgt_reg)
            state_next = DONE;
          else
            state_next = STEP;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign tgt_ready = (state_reg == IDLE);
  assign busy      = (state_reg == STEP) || (state_reg == SETTLE);
  assign done      = (state_reg == DONE);
  assign cur_code  = cur_reg;

  flb_code_stepper_b2t #(.CODE_W(CODE_W)) u_b2t (
    .code   (cur_reg),
    .thermo (thermo)
  );

endmodule

// File: tb/tb_flb_code_stepper.sv
// Bench for flb_code_stepper: directed scenarios plus random traffic against a timeline model.
module tb_flb_code_stepper;

  localparam int CODE_W = 4;
  localparam int SC     = 8;
  localparam int INIT   = 0;
  localparam int TW     = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CODE_W-1:0] tgt_code = '0;
  logic              tgt_valid = 1'b0;
  logic              tgt_ready;
  logic              hold = 1'b0;
  logic [CODE_W-1:0] cur_code;
  logic [TW-1:0]     thermo;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  flb_code_stepper #(
    .CODE_W        (CODE_W),
    .SETTLE_CYCLES (SC),
    .INIT_CODE     (INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_code  (tgt_code),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .hold      (hold),
    .cur_code  (cur_code),
    .thermo    (thermo),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 ramping, 2 done pulse; progress m_p counts un-held ramp edges.
  int m_ph = 0;
  int m_cur = INIT;
  int m_tgt = INIT;
  int m_start = INIT;
  int m_n = 0;
  int m_dir = 1;
  int m_p = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int thermo_of(input int c);
    return (1 << c) - 1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cur = INIT; m_tgt = INIT; m_n = 0; m_p = 0;
  endtask

  task automatic model_edge(input logic v, input int code, input logic h);
    case (m_ph)
      0: if (v) begin
        m_tgt   = code;
        m_start = m_cur;
        m_n     = (code > m_cur) ? code - m_cur : m_cur - code;
        m_dir   = (code > m_cur) ? 1 : -1;
        m_p     = 0;
        m_ph    = (m_n == 0) ? 2 : 1;
        $display("accept: target=%0d from=%0d steps=%0d t=%0t", code, m_start, m_n, $time);
      end
      1: begin
        if (!h) m_p++;
        m_cur = m_start + m_dir * ((m_p + SC) / (SC + 1));
        if (m_p == m_n * (SC + 1)) m_ph = 2;
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic check_outputs();
    chk("cur_code", 32'(cur_code), 32'(m_cur));
    chk("thermo", 32'(thermo), 32'(thermo_of(m_cur)));
    chk("tgt_ready", 32'(tgt_ready), 32'(m_ph == 0));
    chk("busy", 32'(busy), 32'(m_ph == 1));
    chk("done", 32'(done), 32'(m_ph == 2));
    if (m_ph == 2) $display("done: code=%0d t=%0t", m_cur, $time);
  endtask

  task automatic cyc(input logic v, input int code, input logic h);
    tgt_valid = v;
    tgt_code  = CODE_W'(code);
    hold      = h;
    @(posedge clk);
    model_edge(v, code, h);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must snap before the next edge.
  task automatic mid_cycle_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b0;

    // 0 -> 3 ramp
    cyc(1'b1, 3, 1'b0);
    idle_cycles(35);
    chk("ramp3_end", 32'(thermo), 32'h0007);

    // up to 15, then down to 12
    cyc(1'b1, 15, 1'b0);
    idle_cycles(120);
    cyc(1'b1, 12, 1'b0);
    idle_cycles(32);
    chk("ramp12_end", 32'(thermo), 32'h0FFF);

    // zero-length ramp
    cyc(1'b1, 12, 1'b0);
    idle_cycles(3);

    // back to 0, then 0 -> 5 with a 20-cycle hold and a rejected target of 9
    cyc(1'b1, 0, 1'b0);
    idle_cycles(115);
    cyc(1'b1, 5, 1'b0);
    idle_cycles(12);
    for (int i = 0; i < 20; i++) cyc(i == 5 || i == 6, 9, 1'b1);
    cyc(1'b1, 9, 1'b0);
    idle_cycles(50);
    chk("final5", 32'(cur_code), 32'd5);

    // 5 -> 10, reset once code 6 is applied
    cyc(1'b1, 10, 1'b0);
    for (int i = 0; i < 40 && m_cur != 6; i++) cyc(1'b0, 0, 1'b0);
    chk("reached6", 32'(cur_code), 32'd6);
    mid_cycle_reset();
    idle_cycles(2);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        mid_cycle_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
